// File: rtl/sequential_divider_pkg.sv
// Shared types and defaults for the sequential restoring divider.
// Optional feature macro: SEQUENTIAL_DIVIDER_DBZ_EN (early divide-by-zero exit).
package sequential_divider_pkg;

  localparam int unsigned DIV_DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/sequential_divider_if.sv
// Operand/result handshake bundle for the sequential divider.
// div_by_zero exists only when SEQUENTIAL_DIVIDER_DBZ_EN is defined.
interface sequential_divider_if
  import sequential_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_DEFAULT_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
`ifdef SEQUENTIAL_DIVIDER_DBZ_EN
  logic             div_by_zero;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, q, r, div_by_zero
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, q, r, div_by_zero
  );
`else
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, q, r
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, q, r
  );
`endif

endinterface

// File: rtl/sequential_divider_step.sv
// One restoring shift-subtract iteration of the divider datapath.
module divider_step #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] qsr,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   rem_next,
  output logic [WIDTH-1:0] qsr_next
);

  logic [2*WIDTH:0] shifted;
  logic [WIDTH:0]   trial;

  // Shift {rem, qsr} left, trial-subtract the divisor, keep the difference if non-negative
  always_comb begin
    shifted  = {rem, qsr} << 1;
    trial    = shifted[2*WIDTH:WIDTH] - {1'b0, b};
    rem_next = shifted[2*WIDTH:WIDTH];
    qsr_next = shifted[WIDTH-1:0];
    if (!trial[WIDTH]) begin
      rem_next    = trial;
      qsr_next[0] = 1'b1;
    end
  end

endmodule

// File: rtl/sequential_divider.sv
// Multi-cycle unsigned divider, one quotient bit per cycle, valid/ready on both sides.
// Optional feature macro: SEQUENTIAL_DIVIDER_DBZ_EN (b == 0 finishes immediately and flags div_by_zero).
module sequential_divider
  import sequential_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_DEFAULT_WIDTH
) (
  input logic                clk,
  input logic                rst,
  sequential_divider_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  div_state_t       state;
  logic [CNT_W-1:0] step_cnt;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] qsr;
  logic [WIDTH-1:0] divisor;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] qsr_next;
`ifdef SEQUENTIAL_DIVIDER_DBZ_EN
  logic             dbz_r;
`endif

  divider_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .qsr      (qsr),
    .b        (divisor),
    .rem_next (rem_next),
    .qsr_next (qsr_next)
  );

  // Control FSM, step counter, iteration registers and registered result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      step_cnt    <= '0;
      rem         <= '0;
      qsr         <= '0;
      divisor     <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      q_r         <= '0;
      r_r         <= '0;
`ifdef SEQUENTIAL_DIVIDER_DBZ_EN
      dbz_r       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            divisor    <= bus.b;
            qsr        <= bus.a;
            rem        <= '0;
            step_cnt   <= '0;
            in_ready_r <= 1'b0;
`ifdef SEQUENTIAL_DIVIDER_DBZ_EN
            if (bus.b == '0) begin
              state       <= DONE;
              out_valid_r <= 1'b1;
              q_r         <= '1;
              r_r         <= bus.a;
              dbz_r       <= 1'b1;
            end else begin
              state <= BUSY;
            end
`else
            state <= BUSY;
`endif
          end
        end
        BUSY: begin
          rem      <= rem_next;
          qsr      <= qsr_next;
          step_cnt <= step_cnt + CNT_W'(1);
          if (step_cnt == CNT_W'(WIDTH - 1)) begin
            state       <= DONE;
            out_valid_r <= 1'b1;
            q_r         <= qsr_next;
            r_r         <= rem_next[WIDTH-1:0];
`ifdef SEQUENTIAL_DIVIDER_DBZ_EN
            dbz_r       <= 1'b0;
`endif
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.q         = q_r;
  assign bus.r         = r_r;
`ifdef SEQUENTIAL_DIVIDER_DBZ_EN
  assign bus.div_by_zero = dbz_r;
`endif

endmodule

// File: tb/tb_sequential_divider.sv
// Self-checking bench for sequential_divider (WIDTH=16), directed table plus random traffic.
// Honours SEQUENTIAL_DIVIDER_DBZ_EN the same way as the design.
module tb_sequential_divider;

  localparam int unsigned W = 16;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  sequential_divider_if #(.WIDTH(W)) bus ();

  sequential_divider #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    int           stall;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, got, got, exp, exp, $time);
    end
  endtask

  // Expected latency in clock edges after the accept edge until out_valid is seen
  function automatic int exp_latency(input logic [W-1:0] b);
`ifdef SEQUENTIAL_DIVIDER_DBZ_EN
    if (b == '0) return 0;
`endif
    return int'(W);
  endfunction

  // Issue one division, wait for the result, hold it under backpressure, then consume it
  task automatic run_div(input logic [W-1:0] ta, input logic [W-1:0] tb_, input int stall,
                         input logic noisy, output logic [W-1:0] gq, output logic [W-1:0] gr,
                         output int lat, output logic gdbz);
    int waited;
    waited = 0;
    while (!bus.in_ready && waited < 50) begin
      @(posedge clk); #1; waited++;
    end
    check("in_ready_before_accept", 64'(bus.in_ready), 64'd1);
    bus.a        = ta;
    bus.b        = tb_;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = noisy;
    bus.a        = W'($urandom);
    bus.b        = W'($urandom);
    check("in_ready_after_accept", 64'(bus.in_ready), 64'd0);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    bus.in_valid = 1'b0;
    check("out_valid_timeout", 64'(bus.out_valid), 64'd1);
    gq = bus.q;
    gr = bus.r;
`ifdef SEQUENTIAL_DIVIDER_DBZ_EN
    gdbz = bus.div_by_zero;
`else
    gdbz = 1'b0;
`endif
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check("stall_q_stable", 64'(bus.q), 64'(gq));
      check("stall_r_stable", 64'(bus.r), 64'(gr));
      check("stall_out_valid", 64'(bus.out_valid), 64'd1);
      check("stall_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("consume_in_ready", 64'(bus.in_ready), 64'd1);
    check("consume_out_valid", 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         vecs[$];
    logic [W-1:0] gq, gr, ra, rb, eq, er;
    logic         gdbz;
    int           lat;
    bit           saw_valid;

    n_checks = 0;
    n_fail   = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", 64'(bus.in_ready), 64'd1);
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_q", 64'(bus.q), 64'd0);
    check("reset_r", 64'(bus.r), 64'd0);
`ifdef SEQUENTIAL_DIVIDER_DBZ_EN
    check("reset_dbz", 64'(bus.div_by_zero), 64'd0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors with hand-computed results
    vecs.push_back('{a: 16'd100,    b: 16'd7, q: 16'd14,     r: 16'd2,    stall: 0});
    vecs.push_back('{a: 16'hFFFF,   b: 16'd1, q: 16'hFFFF,   r: 16'd0,    stall: 0});
    vecs.push_back('{a: 16'd5,      b: 16'd9, q: 16'd0,      r: 16'd5,    stall: 0});
    vecs.push_back('{a: 16'd1234,   b: 16'd0, q: 16'hFFFF,   r: 16'd1234, stall: 0});
    vecs.push_back('{a: 16'd40000,  b: 16'd3, q: 16'd13333,  r: 16'd1,    stall: 5});
    vecs.push_back('{a: 16'hFFFF,   b: 16'hFFFF, q: 16'd1,   r: 16'd0,    stall: 2});
    vecs.push_back('{a: 16'h8000,   b: 16'hFFFF, q: 16'd0,   r: 16'h8000, stall: 0});

    foreach (vecs[i]) begin
      run_div(vecs[i].a, vecs[i].b, vecs[i].stall, 1'b0, gq, gr, lat, gdbz);
      check("vec_q", 64'(gq), 64'(vecs[i].q));
      check("vec_r", 64'(gr), 64'(vecs[i].r));
      check("vec_latency", 64'(lat), 64'(exp_latency(vecs[i].b)));
`ifdef SEQUENTIAL_DIVIDER_DBZ_EN
      check("vec_dbz", 64'(gdbz), 64'(vecs[i].b == '0));
`endif
    end

    // Reset in the middle of a division: nothing comes out, divider is idle right after
    bus.a = 16'd999; bus.b = 16'd10; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    saw_valid = 1'b0;
    repeat (7) begin
      @(posedge clk); #1;
      if (bus.out_valid) saw_valid = 1'b1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midreset_in_ready", 64'(bus.in_ready), 64'd1);
    check("midreset_out_valid", 64'(bus.out_valid), 64'd0);
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.out_valid) saw_valid = 1'b1;
    end
    check("midreset_no_result", 64'(saw_valid), 64'd0);
    check("midreset_idle", 64'(bus.in_ready), 64'd1);
    run_div(16'd50, 16'd6, 0, 1'b0, gq, gr, lat, gdbz);
    check("post_reset_q", 64'(gq), 64'd8);
    check("post_reset_r", 64'(gr), 64'd2);
    check("post_reset_latency", 64'(lat), 64'(W));

    // Random operands with stalls and noise on the input side while busy
    for (int n = 0; n < 1000; n++) begin
      ra = W'($urandom);
      case ($urandom_range(0, 9))
        0:       rb = '0;
        1, 2:    rb = W'($urandom_range(1, 15));
        3:       rb = W'($urandom_range(1, 255));
        default: rb = W'($urandom);
      endcase
      if (rb == '0) begin
        eq = '1;
        er = ra;
      end else begin
        eq = ra / rb;
        er = ra % rb;
      end
      run_div(ra, rb, int'($urandom_range(0, 3)), 1'($urandom), gq, gr, lat, gdbz);
      check("rand_q", 64'(gq), 64'(eq));
      check("rand_r", 64'(gr), 64'(er));
      check("rand_latency", 64'(lat), 64'(exp_latency(rb)));
      if (rb != '0) begin
        check("rand_roundtrip", 64'(gq) * 64'(rb) + 64'(gr), 64'(ra));
        check("rand_r_lt_b", 64'(gr < rb), 64'd1);
      end
`ifdef SEQUENTIAL_DIVIDER_DBZ_EN
      check("rand_dbz", 64'(gdbz), 64'(rb == '0));
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
